// File: rtl/oversample_cdr_ctl.sv
// Phase-select controller for the 8x oversampling front end: edge histogram, phase tracking, 0/1/2-bit output.
// Optional OVERSAMPLE_CDR_STATS_EN adds saturating slip and loss-of-lock counters.
module oversample_cdr_ctl #(
  parameter int WLOG       = 8,
  parameter int MIN_EDGES  = 16,
  parameter int LOSS_THR   = 8,
  parameter int INIT_PHASE = 4
) (
  input  logic        c,
  input  logic        r,
  input  logic [7:0]  i,
  output logic [1:0]  o_d,
  output logic [1:0]  o_n,
  output logic [2:0]  phase,
  output logic        lock
`ifdef OVERSAMPLE_CDR_STATS_EN
  ,
  output logic [15:0] slips,
  output logic [7:0]  losses
`endif
);
  localparam int CW = WLOG + 1;

  typedef enum logic {ST_ACQ = 1'b0, ST_LOCK = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [7:0]      s_q;
  logic            px7_q;
  logic [CW-1:0]   cnt_q [8];
  logic [CW-1:0]   cnt_d [8];
  logic [CW-1:0]   fin [8];
  logic [WLOG-1:0] win_q;
  logic [2:0]      phase_q, phase_d;
  logic            wrap_fwd_q, wrap_fwd_d, wrap_bwd_q, wrap_bwd_d;
  logic [1:0]      od_q, od_d, on_q, on_d;
  logic [7:0]      x, e;
  logic            last;
  logic [2:0]      te, cand, diff;
  logic [CW-1:0]   peak, cur;

  // x[t] is the t-th sample in time order; e[0] compares against the previous cycle's last sample.
  always_comb begin
    for (int t = 0; t < 8; t++) x[t] = s_q[7-t];
  end
  assign e    = x ^ {x[6:0], px7_q};
  assign last = (win_q == {WLOG{1'b1}});

  always_comb begin
    for (int t = 0; t < 8; t++) fin[t] = cnt_q[t] + CW'(e[t]);
    te   = 3'd0;
    peak = fin[0];
    for (int t = 1; t < 8; t++) begin
      if (fin[t] > peak) begin
        te   = 3'(t);
        peak = fin[t];
      end
    end
    cand = te + 3'd4;
    cur  = fin[phase_q];
    diff = cand - phase_q;
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    if (last) begin
      if (state_q == ST_ACQ) begin
        if (32'(peak) >= MIN_EDGES) begin
          phase_d = cand;
          state_d = ST_LOCK;
        end
      end else if (32'(cur) > LOSS_THR) begin
        state_d = ST_ACQ;
      end else if (32'(peak) >= MIN_EDGES && diff != 3'd0) begin
        // Shortest circular path; a distance of exactly 4 resolves forward.
        phase_d = (diff <= 3'd4) ? phase_q + 3'd1 : phase_q - 3'd1;
      end
    end
    wrap_fwd_d = (phase_q == 3'd7) && (phase_d == 3'd0);
    wrap_bwd_d = (phase_q == 3'd0) && (phase_d == 3'd7);
    for (int t = 0; t < 8; t++) cnt_d[t] = last ? '0 : fin[t];
  end

  // o_n is the valid count for o_d: the first cycle after a wrap drops or adds one bit.
  always_comb begin
    on_d = 2'd1;
    od_d = {1'b0, s_q[3'd7 - phase_q]};
    if (wrap_fwd_q) begin
      on_d = 2'd0;
      od_d = 2'b00;
    end else if (wrap_bwd_q) begin
      on_d = 2'd2;
      od_d = {px7_q, s_q[0]};
    end
  end

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      state_q    <= ST_ACQ;
      s_q        <= 8'h00;
      px7_q      <= 1'b0;
      win_q      <= '0;
      phase_q    <= 3'(INIT_PHASE);
      wrap_fwd_q <= 1'b0;
      wrap_bwd_q <= 1'b0;
      od_q       <= 2'b00;
      on_q       <= 2'd0;
      for (int t = 0; t < 8; t++) cnt_q[t] <= '0;
    end else begin
      state_q    <= state_d;
      s_q        <= i ^ 8'hAA;
      px7_q      <= s_q[0];
      win_q      <= win_q + 1'b1;
      phase_q    <= phase_d;
      wrap_fwd_q <= wrap_fwd_d;
      wrap_bwd_q <= wrap_bwd_d;
      od_q       <= od_d;
      on_q       <= on_d;
      for (int t = 0; t < 8; t++) cnt_q[t] <= cnt_d[t];
    end
  end

  assign o_d   = od_q;
  assign o_n   = on_q;
  assign phase = phase_q;
  assign lock  = (state_q == ST_LOCK);

`ifdef OVERSAMPLE_CDR_STATS_EN
  logic [15:0] slips_q;
  logic [7:0]  losses_q;

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      slips_q  <= '0;
      losses_q <= '0;
    end else begin
      if ((wrap_fwd_d || wrap_bwd_d) && slips_q != 16'hFFFF) slips_q <= slips_q + 16'd1;
      if (state_q == ST_LOCK && state_d == ST_ACQ && losses_q != 8'hFF) losses_q <= losses_q + 8'd1;
    end
  end

  assign slips  = slips_q;
  assign losses = losses_q;
`endif
endmodule

// File: tb/tb_oversample_cdr_ctl.sv
// Bench for oversample_cdr_ctl: directed phase scenarios plus random data against a window-level model.
// Build with OVERSAMPLE_CDR_STATS_EN defined to also check the slip/loss counters.
module tb_oversample_cdr_ctl;
  localparam int WLOG  = 4;
  localparam int N     = 16;
  localparam int MIN_E = 8;
  localparam int LOSS  = 4;
  localparam int INITP = 4;

  logic       c = 1'b0;
  logic       r = 1'b0;
  logic [7:0] i = 8'h00;
  logic [1:0] o_d, o_n;
  logic [2:0] phase;
  logic       lock;
`ifdef OVERSAMPLE_CDR_STATS_EN
  logic [15:0] slips;
  logic [7:0]  losses;
`endif

  oversample_cdr_ctl #(.WLOG(WLOG), .MIN_EDGES(MIN_E), .LOSS_THR(LOSS), .INIT_PHASE(INITP)) dut (
    .c(c), .r(r), .i(i), .o_d(o_d), .o_n(o_n), .phase(phase), .lock(lock)
`ifdef OVERSAMPLE_CDR_STATS_EN
    , .slips(slips), .losses(losses)
`endif
  );

  always #5 c = ~c;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  logic [7:0] m_sq;
  logic       m_px7;
  int         m_cnt [8];
  int         m_win, m_phase, m_pend, m_slips, m_losses;
  logic       m_lock;
  logic [1:0] m_od, m_on;

  logic [7:0] hist [$];
  int         n_on0, n_on2;
  logic       od1_seen, od1_exp;
  logic       par = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_sq = 8'h00; m_px7 = 1'b0; m_win = 0; m_phase = INITP; m_lock = 1'b0;
    m_pend = 0; m_od = 2'b00; m_on = 2'd0; m_slips = 0; m_losses = 0;
    for (int t = 0; t < 8; t++) m_cnt[t] = 0;
  endfunction

  function automatic void model_edge(input logic [7:0] w);
    int samp [9];
    int fin [8];
    int te, cand, peak, cur, nph, d;
    samp[0] = int'(m_px7);
    for (int t = 0; t < 8; t++) samp[t+1] = int'(m_sq[7-t]);
    if (m_pend == 1) begin
      m_on = 2'd0; m_od = 2'b00;
    end else if (m_pend == 2) begin
      m_on = 2'd2; m_od = {m_px7, m_sq[0]};
    end else begin
      m_on = 2'd1; m_od = {1'b0, m_sq[7-m_phase]};
    end
    for (int t = 0; t < 8; t++) fin[t] = m_cnt[t] + ((samp[t+1] != samp[t]) ? 1 : 0);
    m_pend = 0;
    if (m_win == N - 1) begin
      te = 0;
      for (int t = 1; t < 8; t++) if (fin[t] > fin[te]) te = t;
      peak = fin[te];
      cand = (te + 4) % 8;
      cur  = fin[m_phase];
      nph  = m_phase;
      if (!m_lock) begin
        if (peak >= MIN_E) begin nph = cand; m_lock = 1'b1; end
      end else if (cur > LOSS) begin
        m_lock = 1'b0;
        if (m_losses < 255) m_losses++;
      end else if (peak >= MIN_E) begin
        d = (cand - m_phase + 8) % 8;
        if (d >= 1 && d <= 4) nph = (m_phase + 1) % 8;
        else if (d >= 5) nph = (m_phase + 7) % 8;
      end
      if (m_phase == 7 && nph == 0) m_pend = 1;
      if (m_phase == 0 && nph == 7) m_pend = 2;
      if (m_pend != 0 && m_slips < 65535) m_slips++;
      m_phase = nph;
      for (int t = 0; t < 8; t++) m_cnt[t] = 0;
    end else begin
      for (int t = 0; t < 8; t++) m_cnt[t] = fin[t];
    end
    m_win = (m_win + 1) % N;
    m_px7 = m_sq[0];
    m_sq  = w;
  endfunction

  // Normalised word with one transition just before time index te, alternating polarity per cycle.
  function automatic logic [7:0] pat(input int te, input logic b);
    logic [7:0] s;
    for (int t = 0; t < 8; t++) s[7-t] = (te == 0 || t < te) ? b : ~b;
    return s;
  endfunction

  task automatic step(input logic [7:0] w);
    i = w ^ 8'hAA;
    @(posedge c);
    model_edge(w);
    hist.push_back(w);
    #1;
    chk("phase", 32'(phase), 32'(m_phase));
    chk("lock", 32'(lock), 32'(m_lock));
    chk("o_n", 32'(o_n), 32'(m_on));
    chk("o_d", 32'(o_d), 32'(m_od));
`ifdef OVERSAMPLE_CDR_STATS_EN
    chk("slips", 32'(slips), 32'(m_slips));
    chk("losses", 32'(losses), 32'(m_losses));
`endif
    if (o_n == 2'd0) n_on0++;
    if (o_n == 2'd2 && hist.size() >= 3) begin
      n_on2++;
      od1_seen = o_d[1];
      od1_exp  = hist[hist.size()-3][0];
    end
  endtask

  task automatic run(input int te, input int n);
    for (int k = 0; k < n; k++) begin
      step(pat(te, par));
      par = ~par;
    end
  endtask

  task automatic do_reset();
    #2 r = 1'b1;
    #1;
    model_reset();
    chk("rst_o_n", 32'(o_n), 32'd0);
    chk("rst_o_d", 32'(o_d), 32'd0);
    chk("rst_phase", 32'(phase), 32'(INITP));
    chk("rst_lock", 32'(lock), 32'd0);
`ifdef OVERSAMPLE_CDR_STATS_EN
    chk("rst_slips", 32'(slips), 32'd0);
    chk("rst_losses", 32'(losses), 32'd0);
`endif
    repeat (2) @(posedge c);
    #3 r = 1'b0;
    hist.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    int te;
    model_reset();
    do_reset();

    // Test 1: edges at t=0 -> acquire at phase 4 after the first window
    run(0, N - 1);
    chk("t1_lock_pre", 32'(lock), 32'd0);
    run(0, 1);
    chk("t1_phase", 32'(phase), 32'd4);
    chk("t1_lock", 32'(lock), 32'd1);
    run(0, N);
    chk("t1_od0", 32'(o_d[0]), 32'(hist[hist.size()-2][3]));

    // Test 2: edges move to t=1 -> one step to phase 5, no slips
    n_on0 = 0; n_on2 = 0;
    run(1, 2 * N);
    chk("t2_phase", 32'(phase), 32'd5);
    chk("t2_on_not1", 32'(n_on0 + n_on2), 32'd0);

    // Test 3: walk to phase 7, then cand=0 -> wrap forward with one dropped bit
    run(3, 3 * N);
    chk("t3_phase7", 32'(phase), 32'd7);
    n_on0 = 0;
    run(4, 2 * N);
    chk("t3_phase0", 32'(phase), 32'd0);
    chk("t3_on0_count", 32'(n_on0), 32'd1);
`ifdef OVERSAMPLE_CDR_STATS_EN
    chk("t3_slips", 32'(slips), 32'd1);
`endif

    // Test 4: from phase 0, cand=7 -> wrap backward with one double-bit cycle
    n_on2 = 0;
    run(3, 2 * N);
    chk("t4_phase7", 32'(phase), 32'd7);
    chk("t4_on2_count", 32'(n_on2), 32'd1);
    chk("t4_od1", 32'(od1_seen), 32'(od1_exp));

    // Random edge positions with occasional noise, checked cycle by cycle
    for (int wdw = 0; wdw < 6; wdw++) begin
      te = $urandom_range(0, 7);
      for (int k = 0; k < N; k++) begin
        w = pat(te, par);
        if ($urandom_range(0, 7) == 0) w = w ^ 8'($urandom);
        step(w);
        par = ~par;
      end
    end

    // Test 5: idle line keeps ACQ; then lock at 4 and lose it on edges at t=4
    do_reset();
    for (int k = 0; k < 3 * N; k++) step(8'h00);
    chk("t5_idle_lock", 32'(lock), 32'd0);
    chk("t5_idle_phase", 32'(phase), 32'(INITP));
    run(0, N);
    chk("t5_locked", 32'(lock), 32'd1);
    chk("t5_locked_phase", 32'(phase), 32'd4);
    for (int k = 0; k < N; k++) begin
      w = 8'($urandom);
      w[3] = ~w[4];
      step(w);
    end
    chk("t5_loss", 32'(lock), 32'd0);
`ifdef OVERSAMPLE_CDR_STATS_EN
    chk("t5_losses", 32'(losses), 32'd1);
`endif

    // Test 6: asynchronous reset mid-window, first decision exactly one window after release
    run(0, 5);
    do_reset();
    run(2, N - 1);
    chk("t6_lock_pre", 32'(lock), 32'd0);
    chk("t6_phase_pre", 32'(phase), 32'(INITP));
    run(2, 1);
    chk("t6_lock", 32'(lock), 32'd1);
    chk("t6_phase", 32'(phase), 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
